// File: rtl/data_mem_responder.sv
// Data-memory responder for a small CPU: byte-lane RAM, an LED register and a
// free-running cycle counter, with 1-cycle registered loads and a sticky misalignment flag.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        memwrite_i,
  input  logic        memread_i,
  input  logic [3:0]  sign_mask_i,
  output logic [31:0] read_data_o,
  output logic [7:0]  led_o,
  output logic        misaligned_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [31:0] LED_ADDR  = 32'h0000_2000;
  localparam logic [31:0] CNT_ADDR  = 32'h0000_2004;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] cycle_cnt;

  logic [31:0] ram_offset;
  logic [AW-1:0] word_idx;
  logic        in_ram, sel_led, sel_cnt, mapped;
  logic        is_byte, is_half, is_word, misaligned;
  logic [3:0]  byte_en;
  logic [31:0] wdata_aligned;
  logic [31:0] rd_word, load_val;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign ram_offset = addr_i - ADDR_BASE;
  assign word_idx   = ram_offset[AW+1:2];
  assign in_ram     = (ram_offset < RAM_BYTES);
  assign sel_led    = (addr_i[31:2] == LED_ADDR[31:2]);
  assign sel_cnt    = (addr_i[31:2] == CNT_ADDR[31:2]);
  assign mapped     = in_ram || sel_led || sel_cnt;

  // A non-one-hot size code is rejected exactly like a misaligned access.
  assign is_byte    = (sign_mask_i[2:0] == 3'b001);
  assign is_half    = (sign_mask_i[2:0] == 3'b010);
  assign is_word    = (sign_mask_i[2:0] == 3'b100);
  assign misaligned = !(is_byte || is_half || is_word) ||
                      (is_half && addr_i[0]) ||
                      (is_word && (addr_i[1:0] != 2'b00));

  always_comb begin
    byte_en       = 4'b0000;
    wdata_aligned = wr_data_i;
    if (is_byte) begin
      byte_en       = 4'b0001 << addr_i[1:0];
      wdata_aligned = {4{wr_data_i[7:0]}};
    end else if (is_half) begin
      byte_en       = addr_i[1] ? 4'b1100 : 4'b0011;
      wdata_aligned = {2{wr_data_i[15:0]}};
    end else if (is_word) begin
      byte_en       = 4'b1111;
    end
  end

  // RAM is never cleared; a store landing while reset is held is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && memwrite_i && in_ram && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_aligned[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word  = in_ram ? mem[word_idx] : (sel_cnt ? cycle_cnt : 32'h0);
    byte_val = rd_word[{addr_i[1:0], 3'b000} +: 8];
    half_val = addr_i[1] ? rd_word[31:16] : rd_word[15:0];
    load_val = rd_word;
    if (sel_led) begin
      load_val = {24'h0, led_o};
    end else if (is_byte) begin
      load_val = {{24{byte_val[7] & ~sign_mask_i[3]}}, byte_val};
    end else if (is_half) begin
      load_val = {{16{half_val[15] & ~sign_mask_i[3]}}, half_val};
    end
  end

  // Load results are captured at the request edge, so a load right after a
  // store already sees the updated RAM word and the pre-increment counter.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      read_data_o  <= 32'h0;
      led_o        <= 8'h00;
      misaligned_o <= 1'b0;
      cycle_cnt    <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((memwrite_i || memread_i) && mapped && misaligned) misaligned_o <= 1'b1;
      if (memwrite_i) begin
        if (sel_led && !misaligned) led_o <= wr_data_i[7:0];
        if (memread_i || (mapped && misaligned)) read_data_o <= 32'h0;
      end else if (memread_i) begin
        read_data_o <= (mapped && !misaligned) ? load_val : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed, table-driven bench for data_mem_responder, with hand-written
// sequences for the counter, async reset and counter wrap.
module tb_data_mem_responder;

  localparam logic [3:0] MB  = 4'b0001;
  localparam logic [3:0] MH  = 4'b0010;
  localparam logic [3:0] MW  = 4'b0100;
  localparam logic [3:0] MBU = 4'b1001;
  localparam logic [3:0] MHU = 4'b1010;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [31:0] exp_rd;
    logic [7:0]  exp_led;
    logic        exp_mis;
    string       name;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wr_data_i = '0;
  logic        memwrite_i = 1'b0;
  logic        memread_i = 1'b0;
  logic [3:0]  sign_mask_i = '0;
  logic [31:0] read_data_o;
  logic [7:0]  led_o;
  logic        misaligned_o;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  data_mem_responder dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .addr_i       (addr_i),
    .wr_data_i    (wr_data_i),
    .memwrite_i   (memwrite_i),
    .memread_i    (memread_i),
    .sign_mask_i  (sign_mask_i),
    .read_data_o  (read_data_o),
    .led_o        (led_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t mk(input logic wr, input logic rd, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] mask,
                              input logic [31:0] exp_rd, input logic [7:0] exp_led,
                              input logic exp_mis, input string name);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.mask = mask;
    v.exp_rd = exp_rd; v.exp_led = exp_led; v.exp_mis = exp_mis; v.name = name;
    return v;
  endfunction

  // Drives one request on a falling edge and returns just after the sampling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk_i);
    memwrite_i  = wr;
    memread_i   = rd;
    addr_i      = addr;
    wr_data_i   = data;
    sign_mask_i = mask;
    @(posedge clk_i);
    #1;
    memwrite_i = 1'b0;
    memread_i  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkAll(input string name, input logic [31:0] exp_rd,
                          input logic [7:0] exp_led, input logic exp_mis);
    checkOutput({name, ".rd"}, read_data_o, exp_rd);
    checkOutput({name, ".led"}, {24'h0, led_o}, {24'h0, exp_led});
    checkOutput({name, ".mis"}, {31'h0, misaligned_o}, {31'h0, exp_mis});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back(mk(1, 0, 32'h1000, 32'hDEAD_BEEF, MW,  32'h0000_0004, 8'h00, 0, "sw_deadbeef"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'hDEAD_BEEF, 8'h00, 0, "lw_deadbeef"));
    vecs.push_back(mk(0, 0, 32'h1000, 32'h0,         MW,  32'hDEAD_BEEF, 8'h00, 0, "idle_hold"));
    vecs.push_back(mk(1, 0, 32'h1000, 32'h1122_3344, MW,  32'hDEAD_BEEF, 8'h00, 0, "sw_11223344"));
    vecs.push_back(mk(1, 0, 32'h1003, 32'h0000_0080, MB,  32'hDEAD_BEEF, 8'h00, 0, "sb_80"));
    vecs.push_back(mk(0, 1, 32'h1003, 32'h0,         MB,  32'hFFFF_FF80, 8'h00, 0, "lb_1003"));
    vecs.push_back(mk(0, 1, 32'h1003, 32'h0,         MBU, 32'h0000_0080, 8'h00, 0, "lbu_1003"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'h8022_3344, 8'h00, 0, "lw_after_sb"));
    vecs.push_back(mk(0, 1, 32'h1001, 32'h0,         MB,  32'h0000_0033, 8'h00, 0, "lb_1001"));
    vecs.push_back(mk(1, 0, 32'h1002, 32'h0000_A5A5, MH,  32'h0000_0033, 8'h00, 0, "sh_a5a5"));
    vecs.push_back(mk(0, 1, 32'h1002, 32'h0,         MH,  32'hFFFF_A5A5, 8'h00, 0, "lh_1002"));
    vecs.push_back(mk(0, 1, 32'h1002, 32'h0,         MHU, 32'h0000_A5A5, 8'h00, 0, "lhu_1002"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MH,  32'h0000_3344, 8'h00, 0, "lh_1000"));
    vecs.push_back(mk(1, 0, 32'h2000, 32'h0000_01C3, MW,  32'h0000_3344, 8'hC3, 0, "sw_led"));
    vecs.push_back(mk(0, 1, 32'h2000, 32'h0,         MB,  32'h0000_00C3, 8'hC3, 0, "lb_led"));
    vecs.push_back(mk(1, 0, 32'h3000, 32'h1234_5678, MW,  32'h0000_00C3, 8'hC3, 0, "sw_unmapped"));
    vecs.push_back(mk(0, 1, 32'h3000, 32'h0,         MW,  32'h0000_0000, 8'hC3, 0, "lw_unmapped"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'hA5A5_3344, 8'hC3, 0, "lw_ram_check"));
    vecs.push_back(mk(0, 1, 32'h1001, 32'h0,         MW,  32'h0000_0000, 8'hC3, 1, "lw_misaligned"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'hA5A5_3344, 8'hC3, 1, "lw_unchanged"));
    vecs.push_back(mk(0, 1, 32'h3000, 32'h0,         MW,  32'h0000_0000, 8'hC3, 1, "lw_zero"));
    vecs.push_back(mk(1, 0, 32'h1002, 32'hFFFF_FFFF, MW,  32'h0000_0000, 8'hC3, 1, "sw_misaligned"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'hA5A5_3344, 8'hC3, 1, "lw_after_bad_sw"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         4'b0011, 32'h0,     8'hC3, 1, "ld_bad_mask"));
    vecs.push_back(mk(1, 0, 32'h1000, 32'h0000_00FF, 4'b0000, 32'h0,     8'hC3, 1, "sb_bad_mask"));
    vecs.push_back(mk(0, 1, 32'h1000, 32'h0,         MW,  32'hA5A5_3344, 8'hC3, 1, "lw_after_bad_mask"));
    vecs.push_back(mk(1, 1, 32'h1004, 32'h0000_0001, MW,  32'h0000_0000, 8'hC3, 1, "rw_both"));
    vecs.push_back(mk(0, 1, 32'h1004, 32'h0,         MW,  32'h0000_0001, 8'hC3, 1, "lw_1004"));

    // Reset state, independent of the clock
    #2;
    checkAll("reset_state", 32'h0, 8'h00, 1'b0);

    // First increment lands on the first edge after release; 5th edge samples 4
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (4) @(posedge clk_i);
    applyStimulus(1'b0, 1'b1, 32'h2004, 32'h0, MW);
    checkOutput("cnt_5th_edge", read_data_o, 32'h0000_0004);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].mask);
      checkAll(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_led, vecs[i].exp_mis);
    end

    // Reset mid-store: outputs clear at once and the store is dropped
    @(negedge clk_i);
    memwrite_i  = 1'b1;
    addr_i      = 32'h1004;
    wr_data_i   = 32'h0000_FFFF;
    sign_mask_i = MW;
    reset_n_i   = 1'b0;
    #1;
    checkAll("async_reset", 32'h0, 8'h00, 1'b0);
    @(posedge clk_i);
    @(negedge clk_i);
    memwrite_i = 1'b0;
    reset_n_i  = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h1004, 32'h0, MW);
    checkAll("ram_kept_1004", 32'h0000_0001, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h1000, 32'h0, MW);
    checkAll("ram_kept_1000", 32'hA5A5_3344, 8'h00, 1'b0);

    // Counter wrap: preset, then one increment passes before the first load edge
    @(negedge clk_i);
    force dut.cycle_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.cycle_cnt;
    applyStimulus(1'b0, 1'b1, 32'h2004, 32'h0, MW);
    checkOutput("cnt_fffe", read_data_o, 32'hFFFF_FFFE);
    applyStimulus(1'b0, 1'b1, 32'h2004, 32'h0, MW);
    checkOutput("cnt_ffff", read_data_o, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b1, 32'h2004, 32'h0, MW);
    checkOutput("cnt_wrap", read_data_o, 32'h0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameters SHALL be: ADDR_BASE, default 32'h0000_1000, byte address of RAM word 0; DEPTH_WORDS, default 1024, RAM depth in 32-bit words (power of two).
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  single clock; all state updates on its rising edge
- reset_n_i  in  1  asynchronous, active-low reset
- addr_i  in  32  byte address (from CPU data_mem_addr)
- wr_data_i  in  32  store data
- memwrite_i  in  1  store request, sampled at clock edge
- memread_i  in  1  load request, sampled at clock edge
- sign_mask_i  in  4  [2:0] one-hot size (001 byte, 010 half, 100 word); [3]=1 unsigned load
- read_data_o  out  32  load result (CPU data_mem_out)
- led_o  out  8  LED register
- misaligned_o  out  1  sticky misaligned-access flag

Function
REQ-003 Address map SHALL be: RAM at ADDR_BASE .. ADDR_BASE+4*DEPTH_WORDS-1; LED register at 32'h0000_2000; cycle counter at 32'h0000_2004; all else unmapped.
REQ-004 RAM SHALL be word-wide with 4 byte-lane write enables; word index = (addr_i-ADDR_BASE)>>2.
REQ-005 Stores SHALL commit at the rising edge where memwrite_i=1: byte writes wr_data_i[7:0] into lane addr_i[1:0]; half writes wr_data_i[15:0] into lanes {1,0} (addr_i[1]=0) or {3,2} (addr_i[1]=1); word writes all lanes; other lanes unchanged; sign_mask_i[3] ignored.
REQ-006 Loads SHALL have 1-cycle latency: on an edge with memread_i=1, addr_i[1:0] and sign_mask_i are registered and read_data_o presents the result after that edge until the next load or rejected access.
REQ-007 Load result SHALL be the addressed lane(s) right-justified, sign-extended when sign_mask_i[3]=0, zero-extended when 1; word loads return the full word.
REQ-008 A load in the cycle after a store to the same address SHALL return the newly stored data.
REQ-009 Misaligned access (half with addr_i[0]=1; word with addr_i[1:0]!=0) SHALL suppress the write, return 32'h0 for a load, and set misaligned_o=1 until reset.
REQ-010 Invalid sign_mask_i[2:0] (not one-hot) on a request SHALL be handled as misaligned (REQ-009).
REQ-011 Unmapped writes SHALL be ignored; unmapped reads SHALL return 32'h0; misaligned_o unaffected.
REQ-012 LED store (any size, aligned) SHALL update led_o with wr_data_i[7:0] at the edge; LED load SHALL return {24'h0, led_o} unmodified by sign_mask_i.
REQ-013 Cycle counter SHALL increment by 1 every clock, wrap 32'hFFFF_FFFF->0, ignore writes; a word load returns its value at the sampling edge (before increment).
REQ-014 memread_i and memwrite_i both 1 SHALL be treated as a store only; read_data_o SHALL read 32'h0 after that edge.
REQ-015 When neither request is asserted, read_data_o SHALL hold its value; no state other than the counter changes.

Reset
REQ-016 While reset_n_i=0, read_data_o=0, led_o=0, misaligned_o=0, counter=0, independent of clk_i.
REQ-017 RAM contents SHALL NOT be cleared by reset; reset asserted mid-access SHALL drop the access (no partial write, pending load result replaced by 0).
REQ-018 First counter increment SHALL occur at the first rising edge after reset_n_i deasserts.

Verification
REQ-019 Word store 32'hDEAD_BEEF @0x1000, next-cycle LW @0x1000 -> read_data_o=32'hDEAD_BEEF one cycle after load edge.
REQ-020 SB 8'h80 @0x1003 over 32'h1122_3344, then LB @0x1003 -> 32'hFFFF_FF80; LBU -> 32'h0000_0080; LW -> 32'h8022_3344.
REQ-021 SH 16'hA5A5 @0x1002, then LH -> 32'hFFFF_A5A5, LHU -> 32'h0000_A5A5; LW @0x1001 -> 0, misaligned_o=1, RAM unchanged.
REQ-022 SW 32'h0000_01C3 @0x2000 -> led_o=8'hC3; LB @0x2000 -> 32'h0000_00C3; SW @0x3000 -> no change; LW @0x3000 -> 0.
REQ-023 Counter: after reset, LW @0x2004 sampled on 5th edge -> 4; force counter near 32'hFFFF_FFFF -> wraps to 0.
REQ-024 memread_i=memwrite_i=1 @0x1004 data 32'h1 -> RAM word =1, read_data_o=0; reset_n_i pulsed low mid-test -> outputs 0 immediately, RAM retains 32'h1.
